// File: rtl/usram_stream_loader.sv
// Fetches a contiguous block of 64-bit usram words on a start edge and streams them out with valid/ready.
// A 2-entry buffer absorbs the 1-cycle read latency; reads issue only while buffer plus in-flight data leaves room.
module usram_stream_loader #(
    parameter int DEPTH_W = 14,
    parameter int LEN_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      start,
    input  logic [31:0]      input_base,
    input  logic [LEN_W-1:0] xfer_len,
    output logic [31:0]      usram_raddr,
    output logic             usram_ren,
    input  logic [63:0]      usram_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done_pulse,
    output logic             done_flag
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic               start_q;
    logic               trigger;
    logic               inflight;
    logic               pop;
    logic               issue;
    logic               last_issue;
    logic [DEPTH_W-1:0] waddr;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   rd_cnt;
    logic [LEN_W-1:0]   pop_cnt;
    logic [63:0]        buf_mem [2];
    logic               rd_ptr;
    logic               wr_ptr;
    logic [1:0]         count;
    logic               unused_bits;

    assign unused_bits = ^{start[31:1], input_base[31:DEPTH_W+3], input_base[2:0]};

    assign trigger = start[0] & ~start_q & (state == S_IDLE);
    assign pop     = out_valid & out_ready;

    // Credit: occupancy after this cycle's push/pop must leave a free slot for the new read.
    assign issue = (state == S_RUN) && (rd_cnt < len_q) &&
                   (({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
    assign last_issue = issue && (rd_cnt == len_q - LEN_W'(1));

    assign usram_ren   = issue;
    assign usram_raddr = {{(32-DEPTH_W){1'b0}}, waddr};
    assign out_valid   = (count != 2'd0);
    assign out_data    = buf_mem[rd_ptr];
    assign out_last    = out_valid && (pop_cnt == len_q - LEN_W'(1));
    assign busy        = (state == S_RUN) || (state == S_DRAIN);
    assign done_pulse  = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (trigger) begin
                    state_nxt = (xfer_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_issue) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // All reads issued: finished once nothing is in flight and the buffer empties this cycle.
                if (!inflight && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            start_q    <= 1'b0;
            inflight   <= 1'b0;
            waddr      <= '0;
            len_q      <= '0;
            rd_cnt     <= '0;
            pop_cnt    <= '0;
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
            done_flag  <= 1'b0;
        end else begin
            state    <= state_nxt;
            start_q  <= start[0];
            inflight <= issue;

            if (trigger) begin
                waddr     <= input_base[DEPTH_W+2:3];
                len_q     <= xfer_len;
                rd_cnt    <= '0;
                pop_cnt   <= '0;
                done_flag <= 1'b0;
            end else if (issue) begin
                waddr  <= waddr + DEPTH_W'(1);
                rd_cnt <= rd_cnt + LEN_W'(1);
            end

            if (inflight) begin
                buf_mem[wr_ptr] <= usram_rdata;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr  <= ~rd_ptr;
                pop_cnt <= pop_cnt + LEN_W'(1);
            end
            count <= count + {1'b0, inflight} - {1'b0, pop};

            if (state == S_DONE) begin
                done_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_usram_stream_loader.sv
// Randomized scoreboard bench for usram_stream_loader: expected addresses and beats are queued at stimulus time,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_usram_stream_loader;

    localparam int DEPTH_W = 14;
    localparam int LEN_W   = 16;
    localparam int WORDS   = 1 << DEPTH_W;

    logic             clk;
    logic             rst_n;
    logic [31:0]      start;
    logic [31:0]      input_base;
    logic [LEN_W-1:0] xfer_len;
    logic [31:0]      usram_raddr;
    logic             usram_ren;
    logic [63:0]      usram_rdata;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_data;
    logic             out_last;
    logic             busy;
    logic             done_pulse;
    logic             done_flag;

    usram_stream_loader #(.DEPTH_W(DEPTH_W), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .input_base  (input_base),
        .xfer_len    (xfer_len),
        .usram_raddr (usram_raddr),
        .usram_ren   (usram_ren),
        .usram_rdata (usram_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .done_pulse  (done_pulse),
        .done_flag   (done_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic        l;
    } beat_t;

    logic [63:0] mem [WORDS];
    beat_t       exp_beats [$];
    logic [31:0] exp_addr [$];

    int checks = 0;
    int errors = 0;
    int issued = 0;
    int popped = 0;
    int done_cnt = 0;
    int ready_mode = 0;
    int ready_phase = 0;
    bit hold_vld = 0;
    logic [63:0] hold_dat;
    logic        hold_last;

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural usram: registered read, one cycle latency.
    always @(posedge clk) begin
        if (usram_ren) usram_rdata <= mem[usram_raddr[DEPTH_W-1:0]];
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: begin
                out_ready   = (ready_phase == 0);
                ready_phase = (ready_phase + 1) % 3;
            end
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_vld = 0;
        end else begin
            automatic bit pop_now = out_valid && out_ready;
            if (usram_ren) begin
                if (exp_addr.size() == 0) begin
                    chk_eq("unexpected_ren", usram_raddr, 64'hdead);
                end else begin
                    chk_eq("raddr", usram_raddr, exp_addr.pop_front());
                end
                chk_eq("credit_ok", 64'((issued - popped - int'(pop_now)) < 2), 64'd1);
                issued++;
            end
            if (hold_vld) begin
                chk_eq("stall_valid", out_valid, 1);
                chk_eq("stall_data", out_data, hold_dat);
                chk_eq("stall_last", out_last, hold_last);
            end
            hold_vld  = out_valid && !out_ready;
            hold_dat  = out_data;
            hold_last = out_last;
            if (pop_now) begin
                if (exp_beats.size() == 0) begin
                    chk_eq("unexpected_beat", out_data, 64'hdead);
                end else begin
                    automatic beat_t b = exp_beats.pop_front();
                    chk_eq("beat_data", out_data, b.d);
                    chk_eq("beat_last", out_last, b.l);
                end
                popped++;
            end
            if (done_pulse) begin
                done_cnt++;
                chk_eq("done_after_all_beats", exp_beats.size(), 0);
            end
        end
    end

    function automatic void push_expect(input logic [31:0] base, input int len);
        int word;
        word = int'(base[DEPTH_W+2:3]);
        for (int i = 0; i < len; i++) begin
            automatic int a = (word + i) % WORDS;
            beat_t b;
            b.d = mem[a];
            b.l = (i == len - 1);
            exp_addr.push_back(32'(a));
            exp_beats.push_back(b);
        end
    endfunction

    task automatic run_xfer(input logic [31:0] base, input int len, input int mode,
                            input bit toggle, input bit lat_chk);
        int d0;
        bit seen;
        ready_mode = mode;
        input_base = base;
        xfer_len   = LEN_W'(len);
        push_expect(base, len);
        d0 = done_cnt;
        start = 32'h1;
        tick();
        start = 32'h0;
        chk_eq("flag_cleared_on_trigger", done_flag, 0);
        if (len > 0) chk_eq("busy_after_trigger", busy, 1);
        if (lat_chk) begin
            chk_eq("first_ren_T1", usram_ren, 1);
            tick();
            chk_eq("no_valid_T2", out_valid, 0);
            tick();
            chk_eq("first_valid_T3", out_valid, 1);
        end
        if (toggle) begin
            tick();
            start = 32'h1;
            tick();
            start = 32'h0;
            tick();
            start = 32'h1;
            tick();
            start = 32'h0;
        end
        seen = 0;
        for (int i = 0; i < 600; i++) begin
            if (done_cnt != d0) begin
                seen = 1;
                break;
            end
            tick();
        end
        if (!seen) begin
            chk_eq("done_timeout", 0, 1);
        end
        tick();
        tick();
        chk_eq("single_done_pulse", done_cnt, d0 + 1);
        chk_eq("done_flag_set", done_flag, 1);
        chk_eq("busy_clear", busy, 0);
        chk_eq("addr_queue_empty", exp_addr.size(), 0);
        chk_eq("beat_queue_empty", exp_beats.size(), 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk_eq({tag, "_ren"}, usram_ren, 0);
        chk_eq({tag, "_raddr"}, usram_raddr, 0);
        chk_eq({tag, "_valid"}, out_valid, 0);
        chk_eq({tag, "_data"}, out_data, 0);
        chk_eq({tag, "_last"}, out_last, 0);
        chk_eq({tag, "_busy"}, busy, 0);
        chk_eq({tag, "_done_pulse"}, done_pulse, 0);
        chk_eq({tag, "_done_flag"}, done_flag, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int d0;
        bit seen;
        for (int i = 0; i < WORDS; i++) mem[i] = {$urandom, $urandom};
        for (int i = 0; i < 4; i++) mem[8 + i] = 64'(i);
        rst_n = 1'b0;
        start = '0;
        input_base = '0;
        xfer_len = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        check_zero_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Basic streaming with latency check
        run_xfer(32'h40, 4, 0, 0, 1);
        // Backpressure
        run_xfer(32'h1000, 6, 1, 0, 0);
        // Address wrap
        run_xfer(32'h1FFF0, 4, 0, 0, 0);
        // Zero length
        run_xfer(32'h200, 0, 0, 0, 0);
        // Start edge during RUN ignored, then a fresh transfer
        run_xfer(32'h800, 12, 1, 1, 0);
        run_xfer(32'h808, 3, 0, 0, 0);

        // Reset after two beats of eight
        ready_mode = 0;
        input_base = 32'h3000;
        xfer_len   = LEN_W'(8);
        push_expect(32'h3000, 8);
        p0 = popped;
        start = 32'h1;
        tick();
        start = 32'h0;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            if (popped >= p0 + 2) begin
                seen = 1;
                break;
            end
            tick();
        end
        if (!seen) chk_eq("two_beats_timeout", 0, 1);
        rst_n = 1'b0;
        tick();
        check_zero_outputs("midreset");
        exp_beats.delete();
        exp_addr.delete();
        issued = 0;
        popped = 0;
        d0 = done_cnt;
        rst_n = 1'b1;
        repeat (6) tick();
        chk_eq("no_done_after_reset", done_cnt, d0);
        run_xfer(32'h5550, 5, 0, 0, 0);

        // Randomized transfers
        for (int k = 0; k < 8; k++) begin
            run_xfer($urandom, int'($urandom_range(1, 24)), int'($urandom_range(0, 2)), 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
